// File: rtl/core_div_pkg.sv
// core_div_pkg
// Shared types and defaults for the iterative divide unit.
//   div_op_e    : operation encoding driven on op_i (DIV, DIVU, REM, REMU)
//   div_state_e : control states of the divider FSM
//   XLEN_DEF    : default operand/result width
package core_div_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/core_subtractor.sv
// core_subtractor
// Ripple-carry subtractor: diff = a - b, built as a + ~b + 1 from a chain of
// full adders.
// Ports:
//   a          : minuend
//   b          : subtrahend
//   diff       : a - b, modulo 2^SIZE
//   no_borrow  : carry out of the chain; 1 means a >= b (unsigned)
module core_subtractor
    import core_div_pkg::*;
#(
    parameter int SIZE = XLEN_DEF + 1
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] diff,
    output logic            no_borrow
);

    logic [SIZE:0] carry;

    // A carry-in of one completes the two's complement of b.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < SIZE; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (~b[i]),
            .cin  (carry[i]),
            .sum  (diff[i]),
            .cout (carry[i+1])
        );
    end

    assign no_borrow = carry[SIZE];

endmodule

// File: rtl/full_adder.sv
// full_adder
// One-bit full adder cell used to build the ripple subtractor.
// Ports:
//   a, b  : addend bits
//   cin   : carry in
//   sum   : sum bit
//   cout  : carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/core_divider.sv
// core_divider
// Iterative RV32M divide unit for DIV/DIVU/REM/REMU. Restoring shift-subtract
// on operand magnitudes, one quotient bit per cycle, with the sign applied to
// the result on the way out. Divide-by-zero and signed overflow bypass the
// iteration and complete in one cycle.
// Ports:
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   flush_i  : aborts any in-flight op and drops a pending result
//   valid_i  : request valid
//   ready_o  : unit can accept a request (IDLE only)
//   op_i     : div_op_e encoding
//   a_i      : dividend
//   b_i      : divisor
//   valid_o  : result valid, held until ready_i
//   ready_i  : consumer accepts result
//   result_o : quotient (DIV/DIVU) or remainder (REM/REMU)
module core_divider
    import core_div_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    div_state_e      state;
    div_op_e         op_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] divisor_q;
    logic [CW-1:0]   cnt;
    logic            quo_neg;
    logic            rem_neg;

    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            overflow;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            no_borrow;
    logic            diff_msb_unused;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    // DIV and REM are the signed encodings (op bit 0 clear).
    assign is_signed = ~op_i[0];
    assign a_neg     = is_signed & a_i[XLEN-1];
    assign b_neg     = is_signed & b_i[XLEN-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;
    assign overflow  = is_signed && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i);

    // Partial remainder shifted left with the next dividend bit from quo_q.
    // The remainder stays below the divisor, so the difference always fits
    // in XLEN bits whenever there is no borrow.
    assign shifted = {rem_q, quo_q[XLEN-1]};

    core_subtractor #(
        .SIZE (XLEN + 1)
    ) u_sub (
        .a         (shifted),
        .b         ({1'b0, divisor_q}),
        .diff      (diff),
        .no_borrow (no_borrow)
    );

    assign diff_msb_unused = diff[XLEN];

    // Control FSM and datapath registers; flush outranks everything but reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            ready_o   <= 1'b1;
            valid_o   <= 1'b0;
            cnt       <= '0;
            op_q      <= DIV;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            quo_neg   <= 1'b0;
            rem_neg   <= 1'b0;
        end else if (flush_i) begin
            state   <= IDLE;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        op_q    <= div_op_e'(op_i);
                        ready_o <= 1'b0;
                        if (b_i == '0) begin
                            // Architectural divide-by-zero result, no sign fix.
                            quo_q   <= '1;
                            rem_q   <= a_i;
                            quo_neg <= 1'b0;
                            rem_neg <= 1'b0;
                            state   <= DONE;
                            valid_o <= 1'b1;
                        end else if (overflow) begin
                            quo_q   <= {1'b1, {(XLEN-1){1'b0}}};
                            rem_q   <= '0;
                            quo_neg <= 1'b0;
                            rem_neg <= 1'b0;
                            state   <= DONE;
                            valid_o <= 1'b1;
                        end else begin
                            quo_q     <= a_mag;
                            rem_q     <= '0;
                            divisor_q <= b_mag;
                            quo_neg   <= a_neg ^ b_neg;
                            rem_neg   <= a_neg;
                            cnt       <= CW'(XLEN - 1);
                            state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= no_borrow ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                    quo_q <= {quo_q[XLEN-2:0], no_borrow};
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state   <= DONE;
                        valid_o <= 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state   <= IDLE;
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

    // Sign fix on the magnitudes; result is driven only while in DONE.
    always_comb begin
        quo_fix  = quo_neg ? -quo_q : quo_q;
        rem_fix  = rem_neg ? -rem_q : rem_q;
        result_o = '0;
        if (state == DONE) begin
            result_o = (op_q == REM || op_q == REMU) ? rem_fix : quo_fix;
        end
    end

endmodule

// File: tb/tb_core_divider.sv
// tb_core_divider
// Self-checking bench for core_divider. Requests push their expected result
// onto a scoreboard queue; results are popped and compared when valid_o rises.
module tb_core_divider;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;
    localparam int         LAT     = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid_in;
    logic        ready_out;
    logic [1:0]  op_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] result;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];

    core_divider #(.XLEN(32)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .flush_i  (flush),
        .valid_i  (valid_in),
        .ready_o  (ready_out),
        .op_i     (op_in),
        .a_i      (a_in),
        .b_i      (b_in),
        .valid_o  (valid_out),
        .ready_i  (ready_in),
        .result_o (result)
    );

    always #5 clk = ~clk;

    // Reference behaviour: RISC-V division semantics from SV operators.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            OP_DIV:  return sa / sb;
            OP_DIVU: return a / b;
            OP_REM:  return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return LAT;
    endfunction

    // Called at a negedge; leaves the bench at the first negedge after accept.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit track);
        op_in    = op;
        a_in     = a;
        b_in     = b;
        valid_in = 1'b1;
        if (track) exp_q.push_back(model(op, a, b));
        @(negedge clk);
        valid_in = 1'b0;
        a_in     = $urandom();
        b_in     = $urandom();
    endtask

    // Counts negedges until valid_o; lat = -1 when the bound expires.
    task automatic wait_result(output int lat, output logic [31:0] res);
        lat = -1;
        res = 32'hx;
        for (int i = 1; i <= 60; i++) begin
            if (valid_out === 1'b1) begin
                lat = i;
                res = result;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic pop_expected(output logic [31:0] e);
        if (exp_q.size() == 0) e = 32'hx;
        else e = exp_q.pop_front();
    endtask

    task automatic consume();
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (ready_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %b want 1", ready_out);
        end
        tests_run++;
        if (valid_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %b want 0", valid_out);
        end
        tests_run++;
        if (result !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_result: got %h want 0", result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset: ready %b valid %b want 1/0", ready_out, valid_out);
        end
    endtask

    task automatic test_normal();
        logic [1:0]  ops[4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] as[4]  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] bs[4]  = '{32'd7, 32'd7, 32'd2, 32'd2};
        int          lat;
        logic [31:0] res;
        logic [31:0] e;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 1'b1);
            wait_result(lat, res);
            pop_expected(e);
            tests_run++;
            if (lat != LAT) begin
                tests_failed++;
                $display("[TB] FAIL normal_lat[%0d]: got %0d want %0d", i, lat, LAT);
            end
            tests_run++;
            if (res !== e) begin
                tests_failed++;
                $display("[TB] FAIL normal_res[%0d]: got %h want %h", i, res, e);
            end
            consume();
        end
    endtask

    task automatic test_fast_path();
        logic [1:0]  ops[6] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
        logic [31:0] as[6]  = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000,
                                32'hFFFF_FFFB, 32'hFFFF_FFFB};
        logic [31:0] bs[6]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        int          lat;
        logic [31:0] res;
        logic [31:0] e;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], 1'b1);
            wait_result(lat, res);
            pop_expected(e);
            tests_run++;
            if (lat != 1) begin
                tests_failed++;
                $display("[TB] FAIL fast_lat[%0d]: got %0d want 1", i, lat);
            end
            tests_run++;
            if (res !== e) begin
                tests_failed++;
                $display("[TB] FAIL fast_res[%0d]: got %h want %h", i, res, e);
            end
            consume();
        end
    endtask

    task automatic test_hold();
        int          lat;
        logic [31:0] res;
        logic [31:0] e;
        issue(OP_DIVU, 32'd1000, 32'd10, 1'b1);
        wait_result(lat, res);
        pop_expected(e);
        tests_run++;
        if (res !== e || lat != LAT) begin
            tests_failed++;
            $display("[TB] FAIL hold_res: got %h lat %0d want %h lat %0d", res, lat, e, LAT);
        end
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1;
            op_in    = OP_REMU;
            a_in     = $urandom();
            b_in     = 32'd0;
            tests_run++;
            if (valid_out !== 1'b1 || result !== e || ready_out !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL hold_stable[%0d]: valid %b ready %b res %h want 1/0/%h",
                         i, valid_out, ready_out, result, e);
            end
            @(negedge clk);
        end
        valid_in = 1'b0;
        consume();
        tests_run++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL hold_release: ready %b valid %b want 1/0", ready_out, valid_out);
        end
    endtask

    // Aborts a request at N+10 either by flush or by reset, then checks recovery.
    task automatic test_abort(input bit use_reset);
        bit          seen;
        int          lat;
        logic [31:0] res;
        logic [31:0] e;
        issue(OP_DIVU, 32'hFFFF_0000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            tests_run++;
            if (ready_out !== 1'b1 || valid_out !== 1'b0 || result !== 32'd0) begin
                tests_failed++;
                $display("[TB] FAIL abort_reset_async: ready %b valid %b res %h want 1/0/0",
                         ready_out, valid_out, result);
            end
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        tests_run++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_idle[%0d]: ready %b valid %b want 1/0",
                     use_reset, ready_out, valid_out);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (valid_out !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("[TB] FAIL abort_no_valid[%0d]: got valid 1 want 0", use_reset);
        end
        if (!use_reset) begin
            flush    = 1'b1;
            valid_in = 1'b1;
            op_in    = OP_DIVU;
            a_in     = 32'd5;
            b_in     = 32'd0;
            @(negedge clk);
            flush    = 1'b0;
            valid_in = 1'b0;
            @(negedge clk);
            tests_run++;
            if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL flush_blocks_accept: ready %b valid %b want 1/0",
                         ready_out, valid_out);
            end
        end
        issue(OP_DIVU, 32'd9, 32'd3, 1'b1);
        wait_result(lat, res);
        pop_expected(e);
        tests_run++;
        if (lat != LAT) begin
            tests_failed++;
            $display("[TB] FAIL abort_next_lat[%0d]: got %0d want %0d", use_reset, lat, LAT);
        end
        tests_run++;
        if (res !== e) begin
            tests_failed++;
            $display("[TB] FAIL abort_next_res[%0d]: got %h want %h", use_reset, res, e);
        end
        consume();
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          want_lat;
        logic [31:0] res;
        logic [31:0] e;
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom();
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: begin a = 32'($urandom_range(0, 200)); b = $urandom(); end
                default: b = $urandom();
            endcase
            want_lat = model_lat(op, a, b);
            issue(op, a, b, 1'b1);
            wait_result(lat, res);
            pop_expected(e);
            tests_run++;
            if (lat != want_lat) begin
                tests_failed++;
                $display("[TB] FAIL rand_lat[%0d]: op %0d a %h b %h got %0d want %0d",
                         i, op, a, b, lat, want_lat);
            end
            tests_run++;
            if (res !== e) begin
                tests_failed++;
                $display("[TB] FAIL rand_res[%0d]: op %0d a %h b %h got %h want %h",
                         i, op, a, b, res, e);
            end
            consume();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        flush    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        op_in    = OP_DIVU;
        a_in     = 32'd0;
        b_in     = 32'd0;
        test_reset();
        test_normal();
        test_fast_path();
        test_hold();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
